// File: rtl/seq_alu.sv
// Sequential ALU: handshaked ADD/SUB/SHL/SRA, plus an iterative shift-add MUL
// compiled in only when SEQ_ALU_MUL_EN is defined (otherwise opcode 100 is illegal).
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   op1,
  input  logic [WIDTH-1:0]   op2,
  input  logic [2:0]         opcode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] res,
  output logic               err
);

  localparam int RW = 2 * WIDTH;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_SHL = 3'b010;
  localparam logic [2:0] OP_SRA = 3'b011;
`ifdef SEQ_ALU_MUL_EN
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam int CW = $clog2(WIDTH + 1);
`endif

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  typedef struct packed {
    logic [2:0]       opc;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } req_t;

  state_t         st_q;
  req_t           req_q;
  logic           in_ready_q, out_valid_q, err_q;
  logic [RW-1:0]  res_q;

  logic [RW-1:0]  a_sx, b_sx, a_zx;
  logic [RW-1:0]  alu_res_d;
  logic           alu_err_d;

  assign a_sx = {{WIDTH{req_q.a[WIDTH-1]}}, req_q.a};
  assign b_sx = {{WIDTH{req_q.b[WIDTH-1]}}, req_q.b};
  assign a_zx = {{WIDTH{1'b0}}, req_q.a};

  // Oversized shift amounts naturally saturate to 0 / all-sign-bits.
  always_comb begin
    alu_res_d = '0;
    alu_err_d = 1'b0;
    case (req_q.opc)
      OP_ADD:  alu_res_d = a_sx + b_sx;
      OP_SUB:  alu_res_d = a_sx - b_sx;
      OP_SHL:  alu_res_d = a_zx << req_q.b;
      OP_SRA:  alu_res_d = $signed(a_sx) >>> req_q.b;
      default: alu_err_d = 1'b1;
    endcase
  end

`ifdef SEQ_ALU_MUL_EN
  logic [RW-1:0]    acc_q, mcand_q;
  logic [WIDTH-1:0] mplr_q;
  logic [CW-1:0]    cnt_q;
  logic [RW-1:0]    acc_d;

  assign acc_d = acc_q + (mplr_q[0] ? mcand_q : '0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q        <= IDLE;
      req_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      err_q       <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
      acc_q       <= '0;
      mcand_q     <= '0;
      mplr_q      <= '0;
      cnt_q       <= '0;
`endif
    end else begin
      case (st_q)
        IDLE: begin
          if (in_valid) begin
            req_q      <= '{opc: opcode, a: op1, b: op2};
            st_q       <= EXEC;
            in_ready_q <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
            acc_q      <= '0;
            mcand_q    <= {{WIDTH{1'b0}}, op1};
            mplr_q     <= op2;
            cnt_q      <= '0;
`endif
          end
        end
        EXEC: begin
`ifdef SEQ_ALU_MUL_EN
          if (req_q.opc == OP_MUL) begin
            acc_q   <= acc_d;
            mcand_q <= mcand_q << 1;
            mplr_q  <= mplr_q >> 1;
            cnt_q   <= cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
              res_q       <= acc_d;
              err_q       <= 1'b0;
              st_q        <= DONE;
              out_valid_q <= 1'b1;
            end
          end else
`endif
          begin
            res_q       <= alu_res_d;
            err_q       <= alu_err_d;
            st_q        <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            st_q        <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          st_q        <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign res       = res_q;
  assign err       = err_q;

endmodule
